// File: rtl/coeff_pointwise_mul.sv
// Two-stage streaming multiplier for ML-KEM coefficient pairs; raw product out, no reduction.
// Optional sticky operand range flag enabled by defining COEFF_RANGE_CHECK_EN.
module coeff_pointwise_mul #(
    parameter int COEFF_W = 12,
    parameter int OUT_W   = 32,
    parameter int N_COEFF = 256,
    parameter int Q       = 3329
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_a,
    input  logic [COEFF_W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               done,
`ifdef COEFF_RANGE_CHECK_EN
    output logic               range_err,
`endif
    output logic [7:0]         coeff_idx
);

    localparam logic [7:0] LAST_IDX = 8'(N_COEFF - 1);
    localparam int         PROD_W   = 2 * COEFF_W;

    if (OUT_W < PROD_W || N_COEFF < 1 || N_COEFF > 256 || Q >= (1 << COEFF_W)) begin : g_bad_params
        $error("coeff_pointwise_mul: invalid parameter combination");
    end

    // Handshake: a beat moves on a side when valid && ready are both high at the
    // rising edge; in_ready is the pipeline advance and never looks at in_valid.
    logic               adv;
    logic               in_xfer;
    logic               in_last;
    logic [PROD_W-1:0]  prod;

    logic               s1_valid_q, s1_valid_d;
    logic [COEFF_W-1:0] s1_a_q, s1_a_d;
    logic [COEFF_W-1:0] s1_b_q, s1_b_d;
    logic               s1_last_q, s1_last_d;

    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic [7:0]         coeff_idx_q, coeff_idx_d;

    assign prod = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);

    always_comb begin
        adv     = !out_valid_q || out_ready;
        in_xfer = in_valid && adv;
        in_last = (coeff_idx_q == LAST_IDX);

        coeff_idx_d = coeff_idx_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (in_xfer) begin
            coeff_idx_d = in_last ? 8'd0 : coeff_idx_q + 8'd1;
        end

        // Both stages shift together; a cycle without an input transfer shifts in a bubble.
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_last_d   = in_valid && in_last;
            if (in_valid) begin
                s1_a_d = in_a;
                s1_b_d = in_b;
            end
            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                out_data_d = OUT_W'(prod);
            end
        end

        done_d = out_valid_q && out_ready && out_last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            coeff_idx_q <= 8'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            coeff_idx_q <= coeff_idx_d;
        end
    end

`ifdef COEFF_RANGE_CHECK_EN
    localparam logic [COEFF_W-1:0] Q_C = COEFF_W'(Q);

    logic range_err_q, range_err_d;

    // Sticky: only reset clears it; the offending product still flows through.
    assign range_err_d = range_err_q || (in_xfer && (in_a >= Q_C || in_b >= Q_C));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`endif

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign coeff_idx = coeff_idx_q;

endmodule

// File: doc/coeff_pointwise_mul.md
Name: coeff_pointwise_mul

Overview:
- Streaming pointwise coefficient multiplier for ML-KEM polynomials (q = 3329, N = 256).
- Accepts pairs of reduced 12-bit coefficients and produces the raw 24-bit product, zero-extended to 32 bits.
- Feeds the Montgomery reduction stage directly downstream, which takes a 32-bit operand.
- Two-stage pipeline with valid/ready backpressure, a per-polynomial coefficient counter, and a last/done indication.

Parameters:
- COEFF_W, 12, width of each input coefficient.
- OUT_W, 32, width of product output; must be >= 2*COEFF_W.
- N_COEFF, 256, coefficients per polynomial; last fires on the N_COEFF-th accepted pair.
- Q, 3329, modulus; used only by the optional range check.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  COEFF_W  coefficient A.
- in_b  in  COEFF_W  coefficient B.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- out_data  out  OUT_W  in_a*in_b, zero-extended.
- out_last  out  1  product belongs to the final pair of the polynomial.
- done  out  1  one-cycle pulse when the last product is accepted downstream.
- coeff_idx  out  8  index (0..N_COEFF-1) of the next pair to be accepted.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, done=0, coeff_idx=0, all stage valids cleared.
- Stage 1 registers the operands and tag (a, b, last). Stage 2 registers the product, valid and last.
- Latency: a pair accepted in cycle T appears on out_data in cycle T+2 when out_ready is held high.
- Throughput: 1 pair/cycle sustained.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv. in_ready must not depend combinationally on in_valid.
- Transfer occurs when valid && ready on the respective side. No transfer on in_valid without in_ready.
- Stall: while out_valid && !out_ready, out_data/out_last are held stable and no stage moves. A pair held in stage 1 is retained.
- Bubbles: a cycle with adv=1 and no input transfer shifts an invalid slot into stage 1. Gaps in out_valid match gaps in input transfers.
- Counter: coeff_idx increments on each input transfer. The pair accepted at coeff_idx = N_COEFF-1 is tagged last, and coeff_idx wraps to 0 in the same cycle.
- Back-to-back polynomials need no idle cycle.
- done = out_valid && out_ready && out_last, registered, so it pulses one cycle after the final handshake.
- Arithmetic: unsigned COEFF_W x COEFF_W multiply. Upper OUT_W-2*COEFF_W bits are zero. No modular reduction in this block.
- Reset mid-polynomial discards all in-flight products and restarts the count at 0. No done is generated for the aborted polynomial.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro: COEFF_RANGE_CHECK_EN.
- When defined, add output port range_err (1 bit, reset 0).
- range_err is a sticky flag, set when an accepted pair has in_a >= Q or in_b >= Q. It is cleared only by rst.
- The offending product is still computed and passed through unchanged.
- When not defined, the port and its logic are absent, and no input value affects any flag.

Test Plan:
- Single pair a=3328, b=3328, out_ready=1 -> out_data=0x00A90000 exactly 2 cycles after acceptance; out_last=0; coeff_idx=1.
- Stream 256 pairs a=i, b=1 with out_ready=1:
  - outputs 0..255 appear in order, one per cycle;
  - out_last is high only on value 255;
  - done pulses once, one cycle after that handshake;
  - coeff_idx returns to 0.
- Backpressure with a=5, b=7 streaming:
  - drop out_ready for 3 cycles -> out_data=35 held stable, in_ready=0 and no pair lost or duplicated;
  - after release, count of outputs equals count of accepted inputs.
- Two polynomials back-to-back (512 pairs, no gap) -> out_last high on products 255 and 511 only; exactly two done pulses.
- Assert rst after 100 pairs accepted -> out_valid=0 immediately, coeff_idx=0; next polynomial gives its last on its own 256th pair.
- With COEFF_RANGE_CHECK_EN, send a=3329, b=1 -> out_data=3329 and range_err=1, staying high until rst. Without the macro, the same stimulus gives out_data=3329 and no error port.
